apple_1_emu_mem_port: RTL and testbench
=======================================

APPLE_1_EMU_MEM_PORT -- requirements
Module: apple_1_emu_mem_port

Interface
REQ-001 Parameter ADDR_W, default 15, RAM address width in bits.
REQ-002 Parameter DATA_W, default 8, RAM data width in bits; ADDR_W SHALL be >= DATA_W.
REQ-003 Port clk  input  1  single clock for CPU, host and RAM sides.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port cpu_addr  input  ADDR_W  CPU address, low ADDR_W bits of the address bus.
REQ-006 Port cpu_we  input  1  CPU write enable.
REQ-007 Port cpu_do  input  DATA_W  CPU write data.
REQ-008 Port cpu_di  output  DATA_W  RAM read data to CPU, equal to ram_dout.
REQ-009 Port cpu_rdy  output  1  CPU ready; low stalls the CPU.
REQ-010 Port emu_en  input  1  host request for RAM ownership.
REQ-011 Port emu_active  output  1  high while the host owns the RAM.
REQ-012 Port h_valid  input  1  host command valid.
REQ-013 Port h_ready  output  1  host command accepted when h_valid and h_ready are both high on a rising clk edge.
REQ-014 Port h_cmd  input  2  command: 00 SET_ADDR, 01 WRITE, 10 READ, 11 NOP.
REQ-015 Port h_arg  input  ADDR_W  address for SET_ADDR; low DATA_W bits are data for WRITE.
REQ-016 Port rsp_valid  output  1  one-cycle pulse, READ data valid.
REQ-017 Port rsp_data  output  DATA_W  READ data.
REQ-018 Port ram_addr, ram_we, ram_din  output  ADDR_W/1/DATA_W  synchronous single-port RAM drive.
REQ-019 Port ram_dout  input  DATA_W  RAM read data, valid one cycle after address.

Function
REQ-020 The FSM SHALL have states CPU, GRANT, IDLE, RD and RELEASE.
REQ-021 CPU state: ram_addr=cpu_addr, ram_we=cpu_we, ram_din=cpu_do, cpu_rdy=1, h_ready=0, emu_active=0.
REQ-022 CPU state with emu_en=1 at the clk edge SHALL go to GRANT; GRANT SHALL last exactly 1 cycle with cpu_rdy=0, ram_we=0, then go to IDLE.
REQ-023 In GRANT, IDLE, RD and RELEASE, cpu_rdy SHALL be 0 and ram_addr SHALL be addr_ptr; emu_active SHALL be 1 in IDLE and RD only.
REQ-024 IDLE: h_ready=1; accepted SET_ADDR SHALL load addr_ptr<=h_arg.
REQ-025 IDLE: accepted WRITE SHALL drive ram_we=1 and ram_din=h_arg[DATA_W-1:0] in the same cycle, then addr_ptr+1.
REQ-026 IDLE: accepted READ SHALL go to RD; in RD, h_ready=0, rsp_valid=1, rsp_data=ram_dout, addr_ptr+1, then return to IDLE (2 cycles per READ).
REQ-027 NOP SHALL be accepted with no effect.
REQ-028 addr_ptr increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-029 IDLE with emu_en=0 SHALL go to RELEASE without accepting a command; RELEASE SHALL last 1 cycle (ram_we=0), then go to CPU.
REQ-030 emu_en falling during RD SHALL complete the READ response, then go to RELEASE.
REQ-031 emu_en pulse of one cycle in CPU SHALL still traverse GRANT -> IDLE -> RELEASE -> CPU.
REQ-032 addr_ptr SHALL persist across grants; only SET_ADDR or reset changes it, apart from increments.
REQ-033 rsp_data SHALL hold its last value when rsp_valid=0.

Reset
REQ-034 reset=0 SHALL force, asynchronously, state=CPU, addr_ptr=0, cpu_rdy=1, h_ready=0, rsp_valid=0, rsp_data=0, emu_active=0, ram_we=cpu_we pass-through.
REQ-035 Reset asserted mid-WRITE or mid-READ SHALL abort the operation with no response pulse.

Verification
REQ-036 CPU write 0xA5 to 0x0300 with emu_en=0 -> RAM[0x0300]=0xA5, cpu_rdy stays 1.
REQ-037 emu_en=1, SET_ADDR 0x7FFE, WRITE 0x11, 0x22, 0x33 -> RAM[0x7FFE]=0x11, RAM[0x7FFF]=0x22, RAM[0x0000]=0x33 (wrap).
REQ-038 SET_ADDR 0x7FFE, READ x2 -> two rsp_valid pulses, data 0x11 then 0x22, each 1 cycle after acceptance.
REQ-039 emu_en rise -> cpu_rdy=0 on the next edge, h_ready=1 after 2 edges; emu_en fall -> cpu_rdy=1 after RELEASE (2 edges).
REQ-040 emu_en dropped in RD -> rsp_valid pulse still occurs, then RELEASE then CPU.
REQ-041 reset=0 during RD -> rsp_valid=0 immediately, state=CPU, cpu_rdy=1, addr_ptr=0.

Source files
------------

// File: rtl/apple_1_emu_mem_port.sv
// Shares one synchronous single-port RAM between the CPU and a host emulation port.
// The host takes ownership through GRANT and gives it back through RELEASE.
module apple_1_emu_mem_port #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_do,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_rdy,
  input  logic              emu_en,
  output logic              emu_active,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [1:0]        h_cmd,
  input  logic [ADDR_W-1:0] h_arg,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    ST_CPU,
    ST_GRANT,
    ST_IDLE,
    ST_RD,
    ST_RELEASE
  } state_t;

  localparam logic [1:0] CMD_SET_ADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE    = 2'b01;
  localparam logic [1:0] CMD_READ     = 2'b10;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_ptr_reg, addr_ptr_next;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic                host_accept;

  // A command is only taken while the host still wants the RAM.
  assign host_accept = (state_reg == ST_IDLE) && emu_en && h_valid;
  assign cpu_di      = ram_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_CPU;
      addr_ptr_reg <= '0;
      rsp_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      addr_ptr_reg <= addr_ptr_next;
      if (state_reg == ST_RD) begin
        rsp_data_reg <= ram_dout;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_ptr_next = addr_ptr_reg;
    unique case (state_reg)
      ST_CPU: begin
        if (emu_en) state_next = ST_GRANT;
      end
      ST_GRANT: begin
        state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!emu_en) begin
          state_next = ST_RELEASE;
        end else if (host_accept) begin
          unique case (h_cmd)
            CMD_SET_ADDR: addr_ptr_next = h_arg;
            CMD_WRITE:    addr_ptr_next = addr_ptr_reg + ADDR_W'(1);
            CMD_READ:     state_next    = ST_RD;
            default:      ;
          endcase
        end
      end
      ST_RD: begin
        // Pointer wraps naturally at the address width.
        addr_ptr_next = addr_ptr_reg + ADDR_W'(1);
        state_next    = emu_en ? ST_IDLE : ST_RELEASE;
      end
      ST_RELEASE: begin
        state_next = ST_CPU;
      end
      default: begin
        state_next = ST_CPU;
      end
    endcase
  end

  always_comb begin
    cpu_rdy    = 1'b0;
    emu_active = 1'b0;
    h_ready    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = rsp_data_reg;
    ram_addr   = addr_ptr_reg;
    ram_we     = 1'b0;
    ram_din    = h_arg[DATA_W-1:0];
    unique case (state_reg)
      ST_CPU: begin
        cpu_rdy  = 1'b1;
        ram_addr = cpu_addr;
        ram_we   = cpu_we;
        ram_din  = cpu_do;
      end
      ST_IDLE: begin
        emu_active = 1'b1;
        h_ready    = emu_en;
        ram_we     = host_accept && (h_cmd == CMD_WRITE);
      end
      ST_RD: begin
        emu_active = 1'b1;
        rsp_valid  = 1'b1;
        rsp_data   = ram_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apple_1_emu_mem_port.sv
// Directed bench for apple_1_emu_mem_port with a behavioural synchronous RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_apple_1_emu_mem_port;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam logic [1:0] C_SET = 2'b00, C_WR = 2'b01, C_RD = 2'b10, C_NOP = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_do;
  logic [DATA_W-1:0] cpu_di;
  logic              cpu_rdy;
  logic              emu_en;
  logic              emu_active;
  logic              h_valid;
  logic              h_ready;
  logic [1:0]        h_cmd;
  logic [ADDR_W-1:0] h_arg;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout = '0;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  apple_1_emu_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_do(cpu_do), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
    .emu_en(emu_en), .emu_active(emu_active),
    .h_valid(h_valid), .h_ready(h_ready), .h_cmd(h_cmd), .h_arg(h_arg),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one host command in IDLE; exp_addr is where the pointer should be.
  task automatic host(input logic [1:0] c, input logic [ADDR_W-1:0] a,
                      input logic [ADDR_W-1:0] exp_addr);
    h_valid = 1'b1;
    h_cmd   = c;
    h_arg   = a;
    #1;
    chk("h_ready_cmd", 32'(h_ready), 32'd1);
    chk("ram_addr_cmd", 32'(ram_addr), 32'(exp_addr));
    chk("ram_we_cmd", 32'(ram_we), (c == C_WR) ? 32'd1 : 32'd0);
    if (c == C_WR) chk("ram_din_cmd", 32'(ram_din), 32'(a[DATA_W-1:0]));
    $display("host cmd=%0d arg=%h ptr=%h", c, a, ram_addr);
    tick();
    h_valid = 1'b0;
    h_cmd   = C_NOP;
    #1;
  endtask

  initial begin
    reset = 1'b0; cpu_addr = 15'h0000; cpu_we = 1'b1; cpu_do = 8'h00;
    emu_en = 1'b0; h_valid = 1'b0; h_cmd = C_NOP; h_arg = '0;
    #2;
    chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_h_ready", 32'(h_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_emu_active", 32'(emu_active), 32'd0);
    chk("rst_we_pass1", 32'(ram_we), 32'd1);
    cpu_we = 1'b0; #1;
    chk("rst_we_pass0", 32'(ram_we), 32'd0);
    $display("reset checked");
    tick();
    reset = 1'b1;
    tick();

    // CPU write then read back through cpu_di
    cpu_addr = 15'h0300; cpu_do = 8'hA5; cpu_we = 1'b1; #1;
    chk("cpu_ram_addr", 32'(ram_addr), 32'h0300);
    chk("cpu_ram_we", 32'(ram_we), 32'd1);
    chk("cpu_ram_din", 32'(ram_din), 32'hA5);
    tick();
    cpu_we = 1'b0;
    tick();
    chk("cpu_readback", 32'(cpu_di), 32'hA5);
    chk("cpu_rdy_write", 32'(cpu_rdy), 32'd1);
    $display("cpu write 0300=a5 readback=%h", cpu_di);

    // Grant sequence; cpu_we held high to show the CPU is blocked
    emu_en = 1'b1; cpu_we = 1'b1; #1;
    chk("pre_grant_rdy", 32'(cpu_rdy), 32'd1);
    tick();
    chk("grant_cpu_rdy", 32'(cpu_rdy), 32'd0);
    chk("grant_ram_we", 32'(ram_we), 32'd0);
    chk("grant_h_ready", 32'(h_ready), 32'd0);
    chk("grant_emu_active", 32'(emu_active), 32'd0);
    tick();
    chk("idle_h_ready", 32'(h_ready), 32'd1);
    chk("idle_emu_active", 32'(emu_active), 32'd1);
    chk("idle_ram_we", 32'(ram_we), 32'd0);
    cpu_we = 1'b0;
    $display("granted");

    // Writes across the top of the address space
    host(C_SET, 15'h7FFE, 15'h0000);
    host(C_WR, 15'h0011, 15'h7FFE);
    host(C_WR, 15'h0022, 15'h7FFF);
    host(C_WR, 15'h0033, 15'h0000);
    chk("ptr_after_wrap", 32'(ram_addr), 32'h0001);

    // Reads: each response one cycle after acceptance, then back to IDLE
    host(C_SET, 15'h7FFE, 15'h0001);
    host(C_RD, 15'h0000, 15'h7FFE);
    chk("rd1_valid", 32'(rsp_valid), 32'd1);
    chk("rd1_data", 32'(rsp_data), 32'h11);
    chk("rd1_h_ready", 32'(h_ready), 32'd0);
    tick();
    chk("rd1_pulse_end", 32'(rsp_valid), 32'd0);
    chk("rd1_hold", 32'(rsp_data), 32'h11);
    host(C_RD, 15'h0000, 15'h7FFF);
    chk("rd2_valid", 32'(rsp_valid), 32'd1);
    chk("rd2_data", 32'(rsp_data), 32'h22);
    tick();
    host(C_RD, 15'h0000, 15'h0000);
    chk("rd3_data_wrap", 32'(rsp_data), 32'h33);
    tick();
    host(C_NOP, 15'h1234, 15'h0001);
    chk("nop_ptr", 32'(ram_addr), 32'h0001);
    chk("nop_rsp", 32'(rsp_valid), 32'd0);

    // Drop emu_en with a pending write: must not be accepted
    emu_en = 1'b0; h_valid = 1'b1; h_cmd = C_WR; h_arg = 15'h0055; cpu_we = 1'b1; #1;
    chk("drop_h_ready", 32'(h_ready), 32'd0);
    chk("drop_ram_we", 32'(ram_we), 32'd0);
    tick();
    chk("rel_cpu_rdy", 32'(cpu_rdy), 32'd0);
    chk("rel_ram_we", 32'(ram_we), 32'd0);
    chk("rel_emu_active", 32'(emu_active), 32'd0);
    h_valid = 1'b0; cpu_we = 1'b0;
    tick();
    chk("back_cpu_rdy", 32'(cpu_rdy), 32'd1);
    $display("released");

    // Single-cycle emu_en pulse still runs the whole handshake
    emu_en = 1'b1;
    tick();
    emu_en = 1'b0; #1;
    chk("pulse_grant_rdy", 32'(cpu_rdy), 32'd0);
    tick();
    chk("pulse_idle_active", 32'(emu_active), 32'd1);
    chk("pulse_idle_h_ready", 32'(h_ready), 32'd0);
    chk("ptr_persist", 32'(ram_addr), 32'h0001);
    tick();
    chk("pulse_rel_active", 32'(emu_active), 32'd0);
    chk("pulse_rel_rdy", 32'(cpu_rdy), 32'd0);
    tick();
    chk("pulse_cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("pulse_cpu_addr", 32'(ram_addr), 32'h0300);
    $display("pulse handshake done");

    // emu_en drops while a READ is in flight
    emu_en = 1'b1;
    tick();
    tick();
    host(C_SET, 15'h0300, 15'h0001);
    host(C_RD, 15'h0000, 15'h0300);
    emu_en = 1'b0; #1;
    chk("rdrop_valid", 32'(rsp_valid), 32'd1);
    chk("rdrop_data", 32'(rsp_data), 32'hA5);
    tick();
    chk("rdrop_rel_valid", 32'(rsp_valid), 32'd0);
    chk("rdrop_rel_rdy", 32'(cpu_rdy), 32'd0);
    chk("rdrop_hold", 32'(rsp_data), 32'hA5);
    tick();
    chk("rdrop_cpu_rdy", 32'(cpu_rdy), 32'd1);

    // Reset during RD aborts the response
    emu_en = 1'b1;
    tick();
    tick();
    host(C_RD, 15'h0000, 15'h0301);
    chk("rrst_valid_before", 32'(rsp_valid), 32'd1);
    reset = 1'b0; #1;
    chk("rrst_valid", 32'(rsp_valid), 32'd0);
    chk("rrst_data", 32'(rsp_data), 32'd0);
    chk("rrst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("rrst_emu_active", 32'(emu_active), 32'd0);
    emu_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    emu_en = 1'b1;
    tick();
    tick();
    chk("rrst_ptr_zero", 32'(ram_addr), 32'h0000);
    chk("rrst_h_ready", 32'(h_ready), 32'd1);
    $display("reset during read checked");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
